// File: rtl/rv32v_element_sequencer_pkg.sv
// Shared encodings, micro-op record and instruction classifier for the RV32V element sequencer.
// The slide instructions are legal only in builds that define RV32V_SLIDE_EN.
package rv32v_element_sequencer_pkg;

  localparam logic [6:0] OPC_OPV   = 7'b1010111;

  localparam logic [2:0] F3_OPFVV  = 3'b001;
  localparam logic [2:0] F3_OPIVI  = 3'b011;
  localparam logic [2:0] F3_OPIVX  = 3'b100;
  localparam logic [2:0] F3_OPFVF  = 3'b101;
  localparam logic [2:0] F3_OPCFG  = 3'b111;

  localparam logic [5:0] F6_VFADD     = 6'b000000;
  localparam logic [5:0] F6_VFSUB     = 6'b000010;
  localparam logic [5:0] F6_VFMIN     = 6'b000100;
  localparam logic [5:0] F6_VFMAX     = 6'b000110;
  localparam logic [5:0] F6_VFSGNJ    = 6'b001000;
  localparam logic [5:0] F6_VFSGNN    = 6'b001001;
  localparam logic [5:0] F6_VFSGNX    = 6'b001010;
  localparam logic [5:0] F6_VSLIDEUP  = 6'b001110;
  localparam logic [5:0] F6_VSLIDEDN  = 6'b001111;
  localparam logic [5:0] F6_VFDIV     = 6'b100000;
  localparam logic [5:0] F6_VFRDIV    = 6'b100001;
  localparam logic [5:0] F6_VFMUL     = 6'b100100;
  localparam logic [5:0] F6_VFMACC    = 6'b101100;
  localparam logic [5:0] F6_VFNMACC   = 6'b101101;
  localparam logic [5:0] F6_VFMSAC    = 6'b101110;
  localparam logic [5:0] F6_VFNMSAC   = 6'b101111;

  typedef enum logic [0:0] {
    SEQ_IDLE  = 1'b0,
    SEQ_ISSUE = 1'b1
  } seq_state_e;

  typedef enum logic [2:0] {
    KIND_ILLEGAL = 3'd0,
    KIND_SETVL   = 3'd1,
    KIND_FP      = 3'd2,
    KIND_SLIDEUP = 3'd3,
    KIND_SLIDEDN = 3'd4
  } inst_kind_e;

  typedef struct packed {
    logic [5:0]  funct6;
    logic [2:0]  funct3;
    logic        vm;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [31:0] scalar;
  } rv32v_uop_t;

  // Legality over funct3/funct6 for an instruction already known to carry the OP-V opcode.
  function automatic inst_kind_e rv32v_classify(input logic [2:0] f3, input logic [5:0] f6,
                                                input logic slide_en);
    inst_kind_e kind;
    logic       fp_op;
    kind = KIND_ILLEGAL;
    case (f6)
      F6_VFADD, F6_VFSUB, F6_VFMIN, F6_VFMAX, F6_VFSGNJ, F6_VFSGNN, F6_VFSGNX,
      F6_VFDIV, F6_VFMUL, F6_VFMACC, F6_VFNMACC, F6_VFMSAC, F6_VFNMSAC: fp_op = 1'b1;
      default: fp_op = 1'b0;
    endcase
    case (f3)
      F3_OPFVV: kind = fp_op ? KIND_FP : KIND_ILLEGAL;
      F3_OPFVF: kind = (fp_op || (f6 == F6_VFRDIV)) ? KIND_FP : KIND_ILLEGAL;
      F3_OPIVI, F3_OPIVX: begin
        if (slide_en && (f6 == F6_VSLIDEUP)) begin
          kind = KIND_SLIDEUP;
        end else if (slide_en && (f6 == F6_VSLIDEDN)) begin
          kind = KIND_SLIDEDN;
        end else begin
          kind = KIND_ILLEGAL;
        end
      end
      F3_OPCFG: kind = KIND_SETVL;
      default:  kind = KIND_ILLEGAL;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/rv32v_element_sequencer_decode.sv
// Combinational classification and field extraction of one raw OP-V instruction.
// The slide offset output exists only when RV32V_SLIDE_EN is defined.
module rv32v_inst_decode
  import rv32v_element_sequencer_pkg::*;
#(
  parameter int unsigned VLMAX = 32
) (
  input  logic [31:0] inst_i,
  input  logic [31:0] rs1_data_i,
  output inst_kind_e  kind_o,
  output rv32v_uop_t  uop_o,
  output logic [31:0] avl_o
`ifdef RV32V_SLIDE_EN
  ,
  output logic [31:0] offset_o
`endif
);

`ifdef RV32V_SLIDE_EN
  localparam logic SLIDE_EN = 1'b1;
`else
  localparam logic SLIDE_EN = 1'b0;
`endif
  localparam logic [31:0] VLMAX_W = VLMAX;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [5:0] funct6;
  logic [4:0] rs1_field;
  inst_kind_e raw_kind;

  assign opcode    = inst_i[6:0];
  assign funct3    = inst_i[14:12];
  assign funct6    = inst_i[31:26];
  assign rs1_field = inst_i[19:15];
  assign raw_kind  = rv32v_classify(funct3, funct6, SLIDE_EN);

  // SETVL with bit 31 set belongs to another configuration form and is rejected
  always_comb begin
    kind_o = KIND_ILLEGAL;
    if (opcode != OPC_OPV) begin
      kind_o = KIND_ILLEGAL;
    end else if ((raw_kind == KIND_SETVL) && inst_i[31]) begin
      kind_o = KIND_ILLEGAL;
    end else begin
      kind_o = raw_kind;
    end
  end

  assign uop_o.funct6 = funct6;
  assign uop_o.funct3 = funct3;
  assign uop_o.vm     = inst_i[25];
  assign uop_o.vd     = inst_i[11:7];
  assign uop_o.vs1    = rs1_field;
  assign uop_o.vs2    = inst_i[24:20];
  assign uop_o.scalar = rs1_data_i;

  assign avl_o = (rs1_field == 5'd0) ? VLMAX_W : rs1_data_i;

`ifdef RV32V_SLIDE_EN
  assign offset_o = (funct3 == F3_OPIVI) ? {27'd0, rs1_field} : rs1_data_i;
`endif

endmodule

// File: rtl/rv32v_element_sequencer.sv
// Expands legal RV32V instructions into per-element micro-ops and holds the vl register.
// Define RV32V_SLIDE_EN to decode and sequence VSLIDEUP/VSLIDEDOWN.
module rv32v_element_sequencer
  import rv32v_element_sequencer_pkg::*;
#(
  parameter int unsigned VLMAX = 32,
  parameter int unsigned IDX_W = $clog2(VLMAX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_valid_i,
  output logic             inst_ready_o,
  input  logic [31:0]      inst_data_i,
  input  logic [31:0]      inst_rs1_data_i,
  output logic             uop_valid_o,
  input  logic             uop_ready_i,
  output logic [5:0]       uop_funct6_o,
  output logic [2:0]       uop_funct3_o,
  output logic             uop_vm_o,
  output logic [4:0]       uop_vd_o,
  output logic [4:0]       uop_vs1_o,
  output logic [4:0]       uop_vs2_o,
  output logic [31:0]      uop_scalar_o,
  output logic [IDX_W-1:0] uop_elem_o,
  output logic [IDX_W-1:0] uop_src_elem_o,
  output logic             uop_src_oob_o,
  output logic             uop_last_o,
  output logic             vl_wb_valid_o,
  output logic [4:0]       vl_wb_rd_o,
  output logic [31:0]      vl_wb_data_o,
  output logic             illegal_valid_o,
  output logic [IDX_W:0]   vl_o
);

  localparam logic [31:0]    VLMAX_W  = VLMAX;
  localparam logic [IDX_W:0] VLMAX_VL = VLMAX[IDX_W:0];

  seq_state_e       state_q, state_d;
  logic [IDX_W:0]   vl_q, vl_d;
  rv32v_uop_t       uop_q, uop_d;
  logic [IDX_W-1:0] elem_q, elem_d;
  logic             last_q, last_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             illegal_q, illegal_d;

  inst_kind_e       dec_kind;
  rv32v_uop_t       dec_uop;
  logic [31:0]      dec_avl;
  logic [IDX_W:0]   setvl_vl;
  logic [IDX_W:0]   vl_last;
  logic [IDX_W-1:0] next_elem;
  logic [IDX_W-1:0] start;
  logic             empty;

`ifdef RV32V_SLIDE_EN
  logic [IDX_W-1:0] src_q, src_d;
  logic             oob_q, oob_d;
  logic [31:0]      offset_q, offset_d;
  logic             down_q, down_d;
  logic [31:0]      dec_offset;
  logic [31:0]      sel_off;
  logic             sel_down;

  // Returns {oob, src}; a zero offset with down=0 yields src == elem for ordinary ops.
  function automatic logic [IDX_W:0] slide_src(input logic [IDX_W-1:0] elem,
                                               input logic [31:0] off, input logic down);
    logic [32:0]    sum;
    logic [IDX_W:0] res;
    sum = {1'b0, off} + {{(33-IDX_W){1'b0}}, elem};
    if (down) begin
      if (sum >= {1'b0, VLMAX_W}) begin
        res = {1'b1, {IDX_W{1'b0}}};
      end else begin
        res = {1'b0, sum[IDX_W-1:0]};
      end
    end else begin
      res = {1'b0, elem - off[IDX_W-1:0]};
    end
    return res;
  endfunction
`endif

  rv32v_inst_decode #(.VLMAX(VLMAX)) u_decode (
    .inst_i     (inst_data_i),
    .rs1_data_i (inst_rs1_data_i),
    .kind_o     (dec_kind),
    .uop_o      (dec_uop),
    .avl_o      (dec_avl)
`ifdef RV32V_SLIDE_EN
    ,
    .offset_o   (dec_offset)
`endif
  );

  assign setvl_vl  = (dec_avl > VLMAX_W) ? VLMAX_VL : dec_avl[IDX_W:0];
  assign vl_last   = vl_q - {{IDX_W{1'b0}}, 1'b1};
  assign next_elem = elem_q + {{(IDX_W-1){1'b0}}, 1'b1};

  // Next-state: decode on accept, then one element per lane handshake
  always_comb begin
    state_d    = state_q;
    vl_d       = vl_q;
    uop_d      = uop_q;
    elem_d     = elem_q;
    last_d     = last_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    illegal_d  = 1'b0;
    start      = '0;
    empty      = 1'b1;
`ifdef RV32V_SLIDE_EN
    src_d      = src_q;
    oob_d      = oob_q;
    offset_d   = offset_q;
    down_d     = down_q;
    sel_off    = 32'd0;
    sel_down   = 1'b0;
`endif
    case (state_q)
      SEQ_IDLE: begin
        if (inst_valid_i) begin
          case (dec_kind)
            KIND_SETVL: begin
              vl_d       = setvl_vl;
              wb_valid_d = 1'b1;
              wb_rd_d    = dec_uop.vd;
              wb_data_d  = {{(31-IDX_W){1'b0}}, setvl_vl};
            end
            KIND_FP: empty = (vl_q == '0);
`ifdef RV32V_SLIDE_EN
            KIND_SLIDEUP: begin
              sel_off = dec_offset;
              start   = dec_offset[IDX_W-1:0];
              empty   = (dec_offset >= {{(31-IDX_W){1'b0}}, vl_q});
            end
            KIND_SLIDEDN: begin
              sel_off  = dec_offset;
              sel_down = 1'b1;
              empty    = (vl_q == '0);
            end
`endif
            default: illegal_d = 1'b1;
          endcase
          if (!empty) begin
            state_d = SEQ_ISSUE;
            uop_d   = dec_uop;
            elem_d  = start;
            last_d  = ({1'b0, start} == vl_last);
`ifdef RV32V_SLIDE_EN
            offset_d       = sel_off;
            down_d         = sel_down;
            {oob_d, src_d} = slide_src(start, sel_off, sel_down);
`endif
          end else begin
            state_d = SEQ_IDLE;
          end
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      SEQ_ISSUE: begin
        if (uop_ready_i) begin
          if (last_q) begin
            state_d = SEQ_IDLE;
          end else begin
            elem_d = next_elem;
            last_d = ({1'b0, next_elem} == vl_last);
`ifdef RV32V_SLIDE_EN
            {oob_d, src_d} = slide_src(next_elem, offset_q, down_q);
`endif
          end
        end else begin
          state_d = SEQ_ISSUE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // State, vl and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEQ_IDLE;
      vl_q       <= '0;
      uop_q      <= '0;
      elem_q     <= '0;
      last_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
      illegal_q  <= 1'b0;
`ifdef RV32V_SLIDE_EN
      src_q      <= '0;
      oob_q      <= 1'b0;
      offset_q   <= 32'd0;
      down_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      vl_q       <= vl_d;
      uop_q      <= uop_d;
      elem_q     <= elem_d;
      last_q     <= last_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      illegal_q  <= illegal_d;
`ifdef RV32V_SLIDE_EN
      src_q      <= src_d;
      oob_q      <= oob_d;
      offset_q   <= offset_d;
      down_q     <= down_d;
`endif
    end
  end

  assign inst_ready_o    = (state_q == SEQ_IDLE);
  assign uop_valid_o     = (state_q == SEQ_ISSUE);
  assign uop_funct6_o    = uop_q.funct6;
  assign uop_funct3_o    = uop_q.funct3;
  assign uop_vm_o        = uop_q.vm;
  assign uop_vd_o        = uop_q.vd;
  assign uop_vs1_o       = uop_q.vs1;
  assign uop_vs2_o       = uop_q.vs2;
  assign uop_scalar_o    = uop_q.scalar;
  assign uop_elem_o      = elem_q;
  assign uop_last_o      = last_q;
  assign vl_wb_valid_o   = wb_valid_q;
  assign vl_wb_rd_o      = wb_rd_q;
  assign vl_wb_data_o    = wb_data_q;
  assign illegal_valid_o = illegal_q;
  assign vl_o            = vl_q;
`ifdef RV32V_SLIDE_EN
  assign uop_src_elem_o  = src_q;
  assign uop_src_oob_o   = oob_q;
`else
  assign uop_src_elem_o  = elem_q;
  assign uop_src_oob_o   = 1'b0;
`endif

endmodule

// File: doc/rv32v_element_sequencer.md
# rv32v_element_sequencer

Consumer side of the RV32V encoding: accepts raw 32-bit OP-V instructions over a valid/ready handshake, decodes them against the rv32v opcode/funct3/funct6 encodings, and expands each legal vector instruction into one element micro-op per active element (0..vl-1). It holds the architectural vl register, updated by SETVL. It sits between the scalar issue stage and the vector FP/permute execution lanes.

## Interface
- VLMAX, 32, maximum elements per vector register; power of two, 2..256
- IDX_W, $clog2(VLMAX), element index width (derived)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- inst_valid  in  1  instruction offered
- inst_ready  out  1  sequencer can accept
- inst_data  in  32  raw instruction
- inst_rs1_data  in  32  scalar rs1 value (AVL, slide offset, or FVF scalar)
- uop_valid  out  1  micro-op valid
- uop_ready  in  1  lane accepts micro-op
- uop_funct6 / uop_funct3  out  6 / 3  operation and operand class
- uop_vm  out  1  mask bit, passed through
- uop_vd, uop_vs1, uop_vs2  out  5 each  register fields
- uop_scalar  out  32  latched inst_rs1_data
- uop_elem  out  IDX_W  destination element index
- uop_src_elem  out  IDX_W  source element index (slides; equals uop_elem otherwise)
- uop_src_oob  out  1  source past VLMAX; lane uses zero
- uop_last  out  1  final micro-op of instruction
- vl_wb_valid  out  1  one-cycle pulse, SETVL result
- vl_wb_rd, vl_wb_data  out  5, 32  SETVL destination and value
- illegal_valid  out  1  one-cycle pulse, instruction rejected
- vl  out  IDX_W+1  current vl

## Operation
- FSM states IDLE, ISSUE. inst_ready = (state == IDLE), no other dependence.
- Decode on accept (inst_valid & inst_ready):
  - opcode != 1010111 -> illegal.
  - SETVL (111): bit31 must be 0, else illegal. AVL = VLMAX if rs1 field == 0, else inst_rs1_data. vl <= min(AVL, VLMAX) (32-bit unsigned compare). Next cycle: vl_wb_valid=1, rd = bits 11:7, data = new vl. vtype bits ignored. Stay IDLE.
  - FVV: funct6 in {VFADD, VFSUB, VFMIN, VFMAX, VFSGNJ, VFSGNN, VFSGNX, VFDIV, VFMUL, VFMACC, VFNMACC, VFMSAC, VFNMSAC}; FVF: same plus VFRDIV; IVI/IVX: VSLIDEUP/VSLIDEDOWN only. All else illegal (incl. IVV, MVV, MVX).
  - Illegal: illegal_valid pulses next cycle, no micro-ops, stay IDLE.
- Element range: normal ops 0..vl-1. Slide offset = zero-extended imm5 (IVI) or inst_rs1_data (IVX).
  - VSLIDEUP: elements offset..vl-1, src = elem-offset; offset >= vl -> zero micro-ops.
  - VSLIDEDOWN: 0..vl-1, src = elem+offset; uop_src_oob=1 (src=0) when elem+offset >= VLMAX (33-bit sum).
- Zero-count (vl==0 or empty slideup): accepted, no micro-ops, no pulse, stay IDLE.
- ISSUE: micro-op fields registered, held stable while uop_valid & !uop_ready. On handshake: uop_last -> IDLE, else elem+1.

## Timing
- Reset: state IDLE, vl=0, every output 0 except inst_ready=1.
- Accept in cycle N -> first micro-op valid N+1; one micro-op per cycle under uop_ready=1.
- Last handshake in cycle M -> inst_ready=1 in M+1; earliest next accept M+1.
- SETVL/illegal pulses in N+1, exactly one cycle; back-to-back SETVL every cycle allowed.
- uop_valid never drops before handshake. Reset mid-ISSUE aborts instruction, no further micro-ops; vl returns to 0.
- vl updated at end of SETVL accept cycle; following instruction uses new value.

## Configuration
- RV32V_SLIDE_EN defined: VSLIDEUP/VSLIDEDOWN decoded and sequenced as above.
- Undefined: IVI/IVX always illegal; uop_src_elem tied to uop_elem, uop_src_oob tied 0; offset datapath removed.

## Structure
- rv32v package gains: rv32v_uop_t struct (micro-op fields), sequencer state enum, legality function over funct3/funct6.
- One sub-module, rv32v_inst_decode: combinational classify (setvl/fp/slide/illegal) and field extraction; sequencer owns all state.

## Test plan
- Reset, then SETVL rs1=7, rd=5, VLMAX=32 -> vl_wb_valid one cycle, rd=5, data=7; vl=7.
- vl=7, VFADD FVV vd=1 vs1=2 vs2=3 -> 7 micro-ops elem 0..6, uop_last only on 6; inst_ready low until cycle after.
- SETVL rs1=100 -> vl=32; then FVF VFRDIV, scalar 0x3F800000 -> 32 micro-ops, uop_scalar=0x3F800000 each.
- uop_ready toggling 1,0,0,1 during issue -> fields stable while stalled, no element skipped or repeated.
- vl=8, VSLIDEUP IVI imm=3 -> elems 3..7, src 0..4; VSLIDEDOWN IVX rs1=30 -> elems 0..7, oob set for elem>=2; without RV32V_SLIDE_EN both -> illegal_valid.
- VFRDIV FVV, MVV op, opcode 0110011 -> illegal_valid each, no micro-ops; vl=0 VFMUL -> no output, inst_ready stays 1.
